// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// status word layout and the transmit FSM encoding.
package uart_pkg;

    localparam logic [63:0] UART_DATA_OFS = 64'd0;
    localparam logic [63:0] UART_STAT_OFS = 64'd8;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_CNT_LSB   = 4;
    localparam int STAT_CNT_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic logic [63:0] status_word(input logic [STAT_CNT_W-1:0] count,
                                                input logic ovf, input logic empty,
                                                input logic full, input logic busy);
        logic [63:0] w;
        w = '0;
        w[STAT_CNT_LSB +: STAT_CNT_W] = count;
        w[STAT_OVF_BIT]   = ovf;
        w[STAT_EMPTY_BIT] = empty;
        w[STAT_FULL_BIT]  = full;
        w[STAT_BUSY_BIT]  = busy;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with one-extra-bit pointers: full/empty fall out of a pointer
// compare and count is the pointer difference.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty are judged on the pre-edge pointers, so a push while full is
    // refused even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_periph.sv
// Bus-attached 8N1 UART transmitter: DATA writes feed a TX FIFO, a bit-timing FSM
// drains it onto tx_out, and a STATUS register reports FIFO state and overflow.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_0000_2000,
    parameter int          CLK_DIV    = 434,
    parameter int          FIFO_DEPTH = 16,
    parameter int          FIFO_AW    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] address,
    inout  wire  [63:0] data,
    input  logic        read,
    input  logic        write,
    output logic        tx_out,
    output logic        tx_busy,
    output uart_state_e fsm_state
);

    localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic             wr_hit, drop, data_rd, stat_rd, stat_rd_q, overflow;
    logic             fifo_full, fifo_empty, pop;
    logic [7:0]       fifo_rdata;
    logic [FIFO_AW:0] fifo_count;
    logic [63:0]      status;
    logic             unused_data_hi;

    uart_state_e      state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift_reg, shift_reg_next;

    assign wr_hit  = write && (address == BASE_ADDR + UART_DATA_OFS);
    assign data_rd = read && (address == BASE_ADDR + UART_DATA_OFS);
    assign stat_rd = read && (address == BASE_ADDR + UART_STAT_OFS);
    assign drop    = wr_hit && fifo_full;
    assign unused_data_hi = ^data[63:8];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_hit),
        .pop   (pop),
        .wdata (data[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign status = status_word(STAT_CNT_W'(fifo_count), overflow, fifo_empty, fifo_full, tx_busy);
    assign data   = stat_rd ? status : (data_rd ? 64'd0 : 64'bz);

    // A read cycle ends on the edge where the STATUS strobe drops; a drop landing
    // on that same edge must win so the overflow is not lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            stat_rd_q <= 1'b0;
        end else begin
            stat_rd_q <= stat_rd;
            if (drop)                       overflow <= 1'b1;
            else if (stat_rd_q && !stat_rd) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_reg_next;
        end
    end

    always_comb begin
        state_next     = state;
        baud_cnt_next  = baud_cnt + CNT_W'(1);
        bit_idx_next   = bit_idx;
        shift_reg_next = shift_reg;
        pop            = 1'b0;
        tx_out         = 1'b1;
        tx_busy        = 1'b1;
        unique case (state)
            ST_IDLE: begin
                tx_busy       = 1'b0;
                baud_cnt_next = '0;
                if (!fifo_empty) begin
                    pop            = 1'b1;
                    shift_reg_next = fifo_rdata;
                    state_next     = ST_START;
                end
            end
            ST_START: begin
                tx_out = 1'b0;
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_out = shift_reg[0];
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_next  = '0;
                    shift_reg_next = {1'b0, shift_reg[7:1]};
                    bit_idx_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_next = '0;
                    state_next    = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: a line monitor decodes frames against a queue
// of expected bytes; bus tasks drive writes and STATUS reads.
module tb_uart_tx_periph;
    import uart_pkg::*;

    localparam int          CLK_DIV = 4;
    localparam int          FRAME   = 10 * CLK_DIV;
    localparam logic [63:0] BASE    = 64'h0000_0000_0000_2000;
    localparam logic [63:0] DATA_A  = BASE;
    localparam logic [63:0] STAT_A  = BASE + 64'd8;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        read     = 1'b0;
    logic        write    = 1'b0;
    logic [63:0] address  = '0;
    logic [63:0] tb_data  = '0;
    logic        tb_drive = 1'b0;
    wire  [63:0] data_bus;
    logic        tx_out, tx_busy;
    uart_state_e fsm_state;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          wr_cyc   = 0;
    bit          monitor_en = 1'b0;
    bit          mon_busy   = 1'b0;
    logic [7:0]  exp_q[$];
    int          start_q[$];
    logic [63:0] v;
    bit          is_z;
    int          lows, n;

    assign data_bus = tb_drive ? tb_data : 64'bz;

    uart_tx_periph #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .data      (data_bus),
        .read      (read),
        .write     (write),
        .tx_out    (tx_out),
        .tx_busy   (tx_busy),
        .fsm_state (fsm_state)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] stat_exp(input int cnt, input bit ovf, input bit empty,
                                             input bit full, input bit busy);
        return {55'b0, 5'(cnt), ovf, empty, full, busy};
    endfunction

    // driver tasks
    task automatic bus_write(input logic [63:0] addr, input logic [63:0] val, input bit accept);
        @(negedge clock);
        address = addr; tb_data = val; tb_drive = 1'b1; write = 1'b1;
        if (accept) exp_q.push_back(val[7:0]);
        @(negedge clock);
        write = 1'b0; tb_drive = 1'b0; wr_cyc = cyc;
    endtask

    task automatic bus_burst(input int count, input int accept_n);
        for (int i = 0; i < count; i++) begin
            @(negedge clock);
            address = DATA_A; tb_data = {$urandom, $urandom}; tb_drive = 1'b1; write = 1'b1;
            if (i < accept_n) exp_q.push_back(tb_data[7:0]);
        end
        @(negedge clock);
        write = 1'b0; tb_drive = 1'b0;
    endtask

    task automatic bus_read(input logic [63:0] addr, output logic [63:0] val);
        @(negedge clock);
        address = addr; read = 1'b1;
        #1 val = data_bus;
        @(negedge clock);
        read = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || mon_busy) && k < 3000) begin
            @(negedge clock);
            k++;
        end
        check(tag, 64'(k < 3000), 64'd1);
    endtask

    // scoreboard: each frame start pops the expected byte and checks every cycle
    initial begin
        forever begin
            @(negedge clock);
            if (monitor_en && reset && tx_out === 1'b0) begin
                logic [7:0] b;
                logic [9:0] fbits;
                mon_busy = 1'b1;
                start_q.push_back(cyc);
                check("frame_queued", 64'(exp_q.size() != 0), 64'd1);
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                fbits = {1'b1, b, 1'b0};
                for (int i = 0; i < 10; i++) begin
                    for (int c = 0; c < CLK_DIV; c++) begin
                        if (i != 0 || c != 0) @(negedge clock);
                        check($sformatf("frame_bit%0d_byte%h", i, b),
                              64'({tx_busy, tx_out}), 64'({1'b1, fbits[i]}));
                    end
                end
                @(negedge clock);
                check("frame_gap_idle", 64'({tx_busy, tx_out}), 64'b01);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        // 1: reset state, then reset asserted mid-frame
        repeat (3) @(negedge clock);
        check("rst_tx_out", 64'(tx_out), 64'd1);
        check("rst_busy", 64'(tx_busy), 64'd0);
        reset = 1'b1;
        bus_read(STAT_A, v);
        check("rst_status", v, 64'h4);
        bus_write(DATA_A, 64'h5A, 1'b0);
        repeat (10) @(negedge clock);
        check("mid_frame_busy", 64'(tx_busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_tx_out", 64'(tx_out), 64'd1);
        check("async_rst_busy", 64'(tx_busy), 64'd0);
        check("async_rst_state", 64'(fsm_state), 64'(ST_IDLE));
        bus_read(STAT_A, v);
        check("in_rst_status", v, 64'h4);
        @(negedge clock);
        reset = 1'b1;
        lows = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clock);
            if (tx_out !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("no_frame_resume", 64'(lows), 64'd0);
        bus_read(STAT_A, v);
        check("post_rst_status", v, 64'h4);
        monitor_en = 1'b1;

        // 2: single byte, latency and bit pattern
        start_q.delete();
        bus_write(DATA_A, 64'hFFFF_FFA5, 1'b1);
        wait_drain("t2_drain");
        check("t2_frames", 64'(start_q.size()), 64'd1);
        check("t2_latency", 64'(start_q[0] - wr_cyc), 64'd1);

        // 3: overflow with FSM busy, sticky flag cleared by STATUS read
        bus_write(DATA_A, 64'h3C, 1'b1);
        bus_burst(17, 16);
        bus_read(STAT_A, v);
        check("t3_full_ovf", v, stat_exp(16, 1, 0, 1, 1));
        bus_read(STAT_A, v);
        check("t3_ovf_cleared", v, stat_exp(16, 0, 0, 1, 1));

        // 4: dropped write on the edge that ends a STATUS read
        @(negedge clock);
        address = STAT_A; read = 1'b1;
        #1 v = data_bus;
        check("t4_pre_status", v, stat_exp(16, 0, 0, 1, 1));
        @(negedge clock);
        read = 1'b0; address = DATA_A; tb_data = 64'h99; tb_drive = 1'b1; write = 1'b1;
        @(negedge clock);
        write = 1'b0; tb_drive = 1'b0;
        bus_read(STAT_A, v);
        check("t4_ovf_kept", v, stat_exp(16, 1, 0, 1, 1));
        bus_read(STAT_A, v);
        check("t4_ovf_cleared", v, stat_exp(16, 0, 0, 1, 1));
        wait_drain("t3_drain");
        bus_read(STAT_A, v);
        check("t3_empty_after", v, stat_exp(0, 0, 1, 0, 0));

        // 5: three back-to-back frames with a single idle cycle between them
        start_q.delete();
        bus_write(DATA_A, 64'h01, 1'b1);
        bus_write(DATA_A, 64'h80, 1'b1);
        bus_write(DATA_A, 64'hFF, 1'b1);
        n = 0;
        while (start_q.size() < 3 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("t5_third_start", 64'(start_q.size()), 64'd3);
        bus_read(STAT_A, v);
        check("t5_empty_busy", v, stat_exp(0, 0, 1, 0, 1));
        wait_drain("t5_drain");
        check("t5_gap_1", 64'(start_q[1] - start_q[0]), 64'(FRAME + 1));
        check("t5_gap_2", 64'(start_q[2] - start_q[1]), 64'(FRAME + 1));

        // 6: bus drive rules and ignored writes
        bus_read(DATA_A, v);
        check("t6_data_reads_zero", v, 64'd0);
        @(negedge clock);
        address = BASE + 64'd16; read = 1'b1;
        #1 is_z = (data_bus === 64'bz);
        @(negedge clock);
        read = 1'b0;
        check("t6_unmapped_read_z", 64'(is_z), 64'd1);
        address = STAT_A;
        #1 is_z = (data_bus === 64'bz);
        check("t6_no_read_z", 64'(is_z), 64'd1);
        bus_write(STAT_A, 64'h77, 1'b0);
        bus_write(BASE + 64'd24, 64'h66, 1'b0);
        repeat (4) @(negedge clock);
        bus_read(STAT_A, v);
        check("t6_ignored_writes", v, stat_exp(0, 0, 1, 0, 0));
        check("t6_line_idle", 64'({tx_busy, tx_out}), 64'b01);

        repeat (5) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
